// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a ROWS x COLS output-stationary systolic array: loads edge buffers,
// drives skewed feed enables, strobes per-anti-diagonal capture and signals done.
module systolic_seq_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K    = 4,
  parameter int AW   = (K > 1) ? $clog2(K) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 acc_mode,
  input  logic                 abort,
  input  logic                 load_valid,
  output logic                 rd_req,
  output logic [ROWS-1:0]      a_wr_en,
  output logic [COLS-1:0]      b_wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic                 clear_acc,
  output logic [ROWS-1:0]      feed_a,
  output logic [COLS-1:0]      feed_b,
  output logic [ROWS+COLS-2:0] path_en,
  output logic                 busy,
  output logic                 done
);

  localparam int L   = ((ROWS > COLS) ? ROWS : COLS) * K;
  localparam int T   = ROWS + COLS - 1 + K;
  localparam int NPE = ROWS + COLS - 1;
  localparam int IW  = $clog2(L + 1);
  localparam int CW  = $clog2(T + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [CW-1:0] c_q, c_d;
  logic          acc_q, acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      c_q     <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    c_d     = c_q;
    acc_d   = acc_q;
    if (abort) begin
      state_d = IDLE;
      i_d     = '0;
      c_d     = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = LOAD;
            acc_d   = acc_mode;
            i_d     = '0;
            c_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (i_q == IW'(L - 1)) begin
              state_d = COMPUTE;
              i_d     = '0;
              c_d     = '0;
            end else begin
              i_d = i_q + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (c_q == CW'(T - 1)) begin
            state_d = DONE;
            c_d     = '0;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Write strobes follow load_valid combinationally; everything else decodes state only.
  always_comb begin
    int unsigned beat_idx;
    int unsigned c_idx;
    beat_idx  = 32'(i_q);
    c_idx     = 32'(c_q);
    rd_req    = 1'b0;
    a_wr_en   = '0;
    b_wr_en   = '0;
    wr_addr   = '0;
    clear_acc = 1'b0;
    feed_a    = '0;
    feed_b    = '0;
    path_en   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      LOAD: begin
        rd_req = 1'b1;
        busy   = 1'b1;
        if (load_valid) begin
          for (int unsigned r = 0; r < ROWS; r++) a_wr_en[r] = (beat_idx / K == r);
          for (int unsigned j = 0; j < COLS; j++) b_wr_en[j] = (beat_idx / K == j);
          wr_addr = AW'(beat_idx % K);
        end
      end
      COMPUTE: begin
        busy      = 1'b1;
        clear_acc = (c_idx == 0) && !acc_q;
        for (int unsigned r = 0; r < ROWS; r++) feed_a[r] = (c_idx >= r) && (c_idx < r + K);
        for (int unsigned j = 0; j < COLS; j++) feed_b[j] = (c_idx >= j) && (c_idx < j + K);
        for (int unsigned d = 0; d < NPE; d++) path_en[d] = (c_idx == d + K);
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
